bus_rr_arbiter: RTL and testbench

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

---
 rtl/bus_rr_arbiter.sv | 104 ++++++++++
 tb/tb_bus_rr_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Four-requester round-robin bus arbiter with a bounded hold time and a shared 4:1 data path.
// The grant is dropped on a voluntary release, a request drop, or hold expiry; timeout marks expiry.
module bus_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    input  logic [3:0] din,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       dout,
    output logic       timeout
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    state_t     state;
    logic [3:0] ptr;
    logic [3:0] hold;
    logic [1:0] ptr_idx;
    logic [1:0] cand;
    logic [1:0] win;
    logic       win_vld;
    logic       vol_rel;
    logic       hold_hit;

    always_comb begin
        ptr_idx = 2'd0;
        unique case (ptr)
            4'b0010: ptr_idx = 2'd1;
            4'b0100: ptr_idx = 2'd2;
            4'b1000: ptr_idx = 2'd3;
            default: ptr_idx = 2'd0;
        endcase
    end

    // First requester at or after the pointer, wrapping 3 -> 0.
    always_comb begin
        win     = 2'd0;
        win_vld = 1'b0;
        cand    = 2'd0;
        for (int unsigned k = 0; k < 4; k++) begin
            cand = ptr_idx + k[1:0];
            if (!win_vld && req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
    end

    assign vol_rel  = done || !req[gnt_id];
    assign hold_hit = (hold == HOLD_LIMIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= 4'b0001;
            hold    <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (win_vld) begin
                        state  <= OWN;
                        gnt    <= 4'b0001 << win;
                        gnt_id <= win;
                        busy   <= 1'b1;
                        hold   <= 4'd1;
                        ptr    <= 4'b0001 << 2'(win + 2'd1);
                    end else begin
                        hold <= '0;
                    end
                end
                OWN: begin
                    if (vol_rel || hold_hit) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        busy    <= 1'b0;
                        hold    <= '0;
                        // A voluntary release coinciding with expiry is not a timeout.
                        timeout <= hold_hit && !vol_rel;
                    end else begin
                        hold    <= hold + 4'd1;
                        timeout <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dout = busy ? din[gnt_id] : 1'b0;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Randomized and directed bench for bus_rr_arbiter against an integer-level ownership model.
// Every cycle compares all outputs with the model and checks one-hot grants and fairness.
module tb_bus_rr_arbiter;

    localparam int MAXH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] din;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       dout;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // Reference model: owner index (-1 = none), pointer index, cycles owned, timeout flag.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    int wait_cnt[4];
    logic [3:0] prev_gnt = '0;
    int grants[$];

    bus_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .din     (din),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .dout    (dout),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit released;
        if (!rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 1'b0;
            for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            end
            if (m_owner >= 0) begin
                m_hold = 1;
                m_ptr  = (m_owner + 1) % 4;
            end
        end else begin
            released = done || !req[m_owner];
            if (released || m_hold == MAXH) begin
                m_to    = !released;
                m_owner = -1;
                m_hold  = 0;
            end else begin
                m_hold++;
                m_to = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) if (!req[i]) wait_cnt[i] = 0;
    endtask

    task automatic compare();
        logic [3:0] eg;
        eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        chk("gnt", gnt, eg);
        chk("gnt_id", gnt_id, (m_owner >= 0) ? m_owner : 0);
        chk("busy", busy, m_owner >= 0);
        chk("timeout", timeout, m_to);
        chk("dout", dout, (m_owner >= 0) ? din[m_owner] : 1'b0);
        chk("onehot", $countones(gnt) <= 1, 1);
        // Fairness judged from the DUT's own grant sequence.
        if (gnt != 4'd0 && prev_gnt == 4'd0) begin
            grants.push_back(int'(gnt_id));
            for (int i = 0; i < 4; i++) begin
                if (i == int'(gnt_id)) wait_cnt[i] = 0;
                else if (req[i]) begin
                    wait_cnt[i]++;
                    chk("fair", wait_cnt[i] <= 3, 1);
                end
            end
        end
        prev_gnt = gnt;
    endtask

    task automatic step(input logic [3:0] r, input logic d, input logic [3:0] di, input logic rs);
        req = r; done = d; din = di; rst = rs;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic do_reset();
        step(4'd0, 1'b0, 4'd0, 1'b0);
        step(4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        int hold_cycles;
        bit to_seen;
        logic [3:0] r;

        req = '0; done = 1'b0; din = '0; rst = 1'b0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;

        // Reset state, reset overriding active requests
        do_reset();
        step(4'b1111, 1'b1, 4'b1111, 1'b0);
        chk("rst_gnt", gnt, 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dout", dout, 1'b0);

        // All requesting, done pulsed each ownership: order 0,1,2,3,0
        grants.delete();
        for (int c = 0; c < 40 && grants.size() < 5; c++)
            step(4'b1111, m_owner >= 0, 4'b0101, 1'b1);
        chk("rr_count", grants.size(), 5);
        for (int i = 0; i < 5; i++) chk("rr_order", (i < grants.size()) ? grants[i] : -1, i % 4);

        // Hold expiry: exactly MAXH cycles of ownership then a timeout pulse
        do_reset();
        hold_cycles = 0; to_seen = 1'b0;
        for (int c = 0; c < 30 && !to_seen; c++) begin
            step(4'b0100, 1'b0, 4'b0100, 1'b1);
            if (gnt == 4'b0100) hold_cycles++;
            if (timeout) to_seen = 1'b1;
        end
        chk("hold_len", hold_cycles, MAXH);
        chk("timeout_seen", to_seen, 1'b1);
        chk("timeout_gnt", gnt, 4'd0);
        step(4'b0100, 1'b0, 4'b0100, 1'b1);
        chk("regrant", gnt, 4'b0100);

        // Shared data path follows the owner
        do_reset();
        step(4'b0010, 1'b0, 4'b0010, 1'b1);
        step(4'b1010, 1'b0, 4'b0010, 1'b1);
        chk("dout_own1", dout, 1'b1);
        step(4'b1000, 1'b0, 4'b1000, 1'b1);
        chk("drop_gnt", gnt, 4'd0);
        step(4'b1000, 1'b0, 4'b1000, 1'b1);
        chk("gnt3", gnt, 4'b1000);
        chk("dout_own3", dout, 1'b1);
        din = 4'b0111; #1;
        chk("dout_own3_lo", dout, 1'b0);

        // done coinciding with expiry is voluntary
        do_reset();
        to_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(4'b0001, (m_owner >= 0 && m_hold == MAXH), 4'b0001, 1'b1);
            if (timeout) to_seen = 1'b1;
        end
        chk("done_at_max", to_seen, 1'b0);

        // Reset mid-ownership, then pointer restarts at requester 0
        do_reset();
        step(4'b0010, 1'b0, 4'b1111, 1'b1);
        step(4'b0110, 1'b0, 4'b1111, 1'b1);
        step(4'b0110, 1'b0, 4'b1111, 1'b1);
        chk("mid_gnt", gnt, 4'b0010);
        step(4'b0110, 1'b0, 4'b1111, 1'b0);
        chk("mid_rst_gnt", gnt, 4'd0);
        chk("mid_rst_to", timeout, 1'b0);
        chk("mid_rst_dout", dout, 1'b0);
        step(4'b0110, 1'b0, 4'b1111, 1'b1);
        chk("post_rst_gnt", gnt, 4'b0010);

        // Random traffic with occasional resets
        r = 4'b1111;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) r[i] = ~r[i];
            step(r, $urandom_range(9) == 0, 4'($urandom), $urandom_range(499) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
